rx_byte_packer: RTL and testbench
=================================

Name: rx_byte_packer

Overview:
- Sits directly downstream of the receiver controller. Consumes its serial descrambled data (oData / oRX_EN) and packs the bits into bytes.
- Buffers the bytes in a small first-word-fall-through (FWFT) FIFO with a valid/ready handshake toward the MAC-side consumer.
- At the end of each received frame, reports a byte count plus partial-byte and overflow status.

Parameters:
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW bytes.
- CNT_W, 13, byte counter width; wide enough for a 12-bit LENGTH plus one padded byte.
- LSB_FIRST, 1, packing order. 1 = first received bit goes to byte[0]; 0 = first bit goes to byte[7].

Ports:
- iClk  in  1  system clock; same clock as the receiver controller.
- iRst  in  1  asynchronous, active-low reset (0 = reset).
- iData  in  1  serial data from the receiver controller (oData).
- iRX_EN  in  1  frame-active level from the receiver controller (oRX_EN).
- iBitEN  in  1  one-cycle bit strobe (single iClk cycle per data bit, integration-generated from the slow-clock rising edge); a bit is sampled only when iBitEN=1.
- iByteReady  in  1  consumer ready.
- oByte  out  8  FIFO head byte.
- oByteValid  out  1  FIFO not empty.
- oFrameDone  out  1  one-cycle end-of-frame pulse.
- oByteCnt  out  CNT_W  bytes pushed for the last or current frame.
- oPartial  out  1  last byte of the frame was zero-padded.
- oOverflow  out  1  sticky per frame; a byte was dropped because the FIFO was full.

Behaviour:
- Reset (iRst=0, asynchronous):
  - State = IDLE; FIFO empty; bit counter = 0; shift register = 0.
  - All outputs 0.
- States: IDLE, COLLECT, FLUSH, DONE.
- IDLE:
  - When iRX_EN=1: clear oByteCnt, oPartial, oOverflow and the bit counter, then go to COLLECT.
  - If iBitEN=1 in that same cycle, iData is taken as bit 0 of the first byte.
- COLLECT:
  - Bit accept = iBitEN & iRX_EN. On accept, the bit is placed per LSB_FIRST and the 3-bit counter increments, wrapping from 7 to 0.
  - When the 8th bit is accepted, the completed byte is pushed on the same edge. oByteValid rises on the next cycle if the FIFO was empty (1-cycle latency).
  - When iRX_EN=0 (iBitEN ignored in that cycle), go to FLUSH.
- FLUSH (exactly 1 cycle):
  - If bit counter != 0: remaining bit positions are filled with 0, the byte is pushed, oPartial is set and the bit counter is cleared.
  - Then go to DONE.
- DONE (exactly 1 cycle):
  - oFrameDone=1; go to IDLE.
  - oByteCnt, oPartial and oOverflow hold their values until the next frame starts.
- FIFO:
  - FWFT: oByte is valid whenever oByteValid=1; pop when oByteValid & iByteReady.
  - Push when full is allowed only if a pop happens in the same cycle. Otherwise the byte is dropped, oOverflow is set and oByteCnt does not increment.
  - Simultaneous push and pop on an empty FIFO: the push lands and no pop occurs.
  - Pointers wrap modulo the depth. The FIFO is not cleared at frame start, so unread bytes of the previous frame remain ahead of the new ones.
- oByteCnt increments once per successful push and saturates at all-ones.
- Reset mid-frame discards everything, including FIFO contents; no oFrameDone pulse is generated.
- A 1-cycle drop of iRX_EN ends the frame (FLUSH, then DONE); the next high level starts a new frame from IDLE.

Optional Feature:
- Macro RX_PACK_CHKSUM_EN.
- Defined:
  - Adds output oChksum (8 bits): XOR of all successfully pushed bytes of the frame, padded byte included.
  - Cleared at frame start; stable from the DONE cycle until the next frame start.
  - Adds output oChksumOK (1 bit), valid in the DONE cycle: 1 when oChksum == 8'h00, i.e. when the frame carries a trailing XOR byte.
- Undefined: neither port exists and no checksum logic is instantiated.

Test Plan:
- Basic byte, LSB_FIRST=1: iRX_EN high, 8 strobes with bits 1,0,1,1,0,0,1,0, iRX_EN low, iByteReady=1 → oByte=8'h4D valid 1 cycle after the 8th strobe; oFrameDone pulse 2 cycles after iRX_EN falls; oByteCnt=1; oPartial=0.
- Partial byte: 11 strobes, all bits 1 → bytes 8'hFF then 8'h07; oPartial=1; oByteCnt=2.
- Backpressure and overflow (FIFO_AW=3, iByteReady=0): 10 full bytes → first 8 stored, oOverflow=1, oByteCnt=8. Then raise iByteReady → exactly 8 bytes drain in order.
- Full FIFO with push and pop in the same cycle: FIFO holds 8 bytes, iByteReady=1 on the cycle the 9th byte completes → no drop, oOverflow=0, 9 bytes read in total.
- Reset mid-frame: pull iRst low after 5 strobes → all outputs 0 asynchronously, FIFO empty. Next frame of 8 bits → one correct byte, oByteCnt=1.
- RX_PACK_CHKSUM_EN defined: bytes 8'h12, 8'h34, 8'h26 → oChksum=8'h00, oChksumOK=1 in the DONE cycle. Bytes 8'h12, 8'h34 → oChksum=8'h26, oChksumOK=0.

Source files
------------

// File: rtl/rx_byte_packer.sv
// rx_byte_packer: packs strobed serial RX bits into bytes behind a FWFT FIFO.
// Optional XOR checksum outputs are enabled by defining RX_PACK_CHKSUM_EN.
`timescale 1ns/1ps
module rx_byte_packer #(
    parameter int FIFO_AW   = 3,
    parameter int CNT_W     = 13,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iData,
    input  logic             iRX_EN,
    input  logic             iBitEN,
    input  logic             iByteReady,
    output logic [7:0]       oByte,
    output logic             oByteValid,
    output logic             oFrameDone,
    output logic [CNT_W-1:0] oByteCnt,
    output logic             oPartial,
    output logic             oOverflow
`ifdef RX_PACK_CHKSUM_EN
    ,
    output logic [7:0]       oChksum,
    output logic             oChksumOK
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_FLUSH   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [FIFO_AW:0] wptr_q, wptr_d;
    logic [FIFO_AW:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             partial_q, partial_d;
    logic             overflow_q, overflow_d;
`ifdef RX_PACK_CHKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif

    logic             empty;
    logic             full;
    logic             pop;
    logic             push_req;
    logic             push_ok;
    logic [7:0]       push_byte;
    logic [2:0]       pos;
    logic [7:0]       with_bit;
    logic [7:0]       first_bit;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                   (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    assign pop   = !empty && iByteReady;

    assign oByte      = empty ? 8'h00 : mem_q[rptr_q[FIFO_AW-1:0]];
    assign oByteValid = !empty;
    assign oFrameDone = (state_q == S_DONE);
    assign oByteCnt   = cnt_q;
    assign oPartial   = partial_q;
    assign oOverflow  = overflow_q;
`ifdef RX_PACK_CHKSUM_EN
    assign oChksum    = chk_q;
    assign oChksumOK  = (state_q == S_DONE) && (chk_q == 8'h00);
`endif

    // Frame FSM, bit packing and FIFO push/pop bookkeeping.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        partial_d  = partial_q;
        overflow_d = overflow_q;
`ifdef RX_PACK_CHKSUM_EN
        chk_d      = chk_q;
`endif
        push_req   = 1'b0;
        push_ok    = 1'b0;
        push_byte  = 8'h00;

        pos           = LSB_FIRST ? bit_cnt_q : (3'd7 - bit_cnt_q);
        with_bit      = shift_q;
        with_bit[pos] = iData;
        first_bit     = 8'h00;
        first_bit[LSB_FIRST ? 3'd0 : 3'd7] = iData;

        case (state_q)
            S_IDLE: begin
                if (iRX_EN) begin
                    cnt_d      = '0;
                    partial_d  = 1'b0;
                    overflow_d = 1'b0;
`ifdef RX_PACK_CHKSUM_EN
                    chk_d      = 8'h00;
`endif
                    bit_cnt_d  = 3'd0;
                    shift_d    = 8'h00;
                    state_d    = S_COLLECT;
                    if (iBitEN) begin
                        shift_d   = first_bit;
                        bit_cnt_d = 3'd1;
                    end
                end
            end
            S_COLLECT: begin
                if (!iRX_EN) begin
                    state_d = S_FLUSH;
                end else if (iBitEN) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        push_req  = 1'b1;
                        push_byte = with_bit;
                        shift_d   = 8'h00;
                    end else begin
                        shift_d = with_bit;
                    end
                end
            end
            S_FLUSH: begin
                if (bit_cnt_q != 3'd0) begin
                    push_req  = 1'b1;
                    push_byte = shift_q;
                    partial_d = 1'b1;
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'h00;
                end
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A full FIFO still accepts a byte when the head leaves this cycle.
        push_ok = push_req && (!full || pop);
        if (push_ok) begin
            mem_d[wptr_q[FIFO_AW-1:0]] = push_byte;
            wptr_d = wptr_q + 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
`ifdef RX_PACK_CHKSUM_EN
            chk_d = chk_q ^ push_byte;
`endif
        end else if (push_req) begin
            overflow_d = 1'b1;
        end

        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    // State registers; reset discards the frame and all buffered bytes.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            partial_q  <= 1'b0;
            overflow_q <= 1'b0;
`ifdef RX_PACK_CHKSUM_EN
            chk_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            partial_q  <= partial_d;
            overflow_q <= overflow_d;
`ifdef RX_PACK_CHKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

endmodule

// File: tb/tb_rx_byte_packer.sv
// tb_rx_byte_packer: directed self-checking bench for rx_byte_packer.
// Checksum vectors run only when RX_PACK_CHKSUM_EN is defined.
`timescale 1ns/1ps
module tb_rx_byte_packer;

    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic        iData = 1'b0;
    logic        iRX_EN = 1'b0;
    logic        iBitEN = 1'b0;
    logic        iByteReady = 1'b0;
    logic [7:0]  oByte;
    logic        oByteValid;
    logic        oFrameDone;
    logic [12:0] oByteCnt;
    logic        oPartial;
    logic        oOverflow;
`ifdef RX_PACK_CHKSUM_EN
    logic [7:0]  oChksum;
    logic        oChksumOK;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] rx_q [$];

    rx_byte_packer dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iData      (iData),
        .iRX_EN     (iRX_EN),
        .iBitEN     (iBitEN),
        .iByteReady (iByteReady),
        .oByte      (oByte),
        .oByteValid (oByteValid),
        .oFrameDone (oFrameDone),
        .oByteCnt   (oByteCnt),
        .oPartial   (oPartial),
        .oOverflow  (oOverflow)
`ifdef RX_PACK_CHKSUM_EN
        ,
        .oChksum    (oChksum),
        .oChksumOK  (oChksumOK)
`endif
    );

    always #5 iClk = ~iClk;

    // Log every byte the consumer accepts (handshake seen mid-cycle).
    always @(negedge iClk) begin
        if (iRst && oByteValid && iByteReady) begin
            rx_q.push_back(oByte);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        iBitEN = 1'b1;
        iData  = b;
        tick();
        iBitEN = 1'b0;
        iData  = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(b[i]);
        end
    endtask

    // Drop iRX_EN and wait for the DONE pulse; leaves the bench in DONE.
    task automatic frame_end(input string tag);
        int lat;
        lat = 0;
        iRX_EN = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (oFrameDone) begin
                lat = i;
                break;
            end
        end
        check({tag, "_done_lat"}, lat, 2);
    endtask

    task automatic check_queue(input string tag, input int idx,
                               input logic [7:0] exp);
        logic [31:0] got;
        got = (idx < rx_q.size()) ? {24'h0, rx_q[idx]} : 32'hDEAD;
        check(tag, got, {24'h0, exp});
    endtask

    initial begin
        // Reset state
        iRst = 1'b0;
        tick();
        tick();
        check("rst_byte", oByte, 0);
        check("rst_valid", oByteValid, 0);
        check("rst_done", oFrameDone, 0);
        check("rst_cnt", oByteCnt, 0);
        check("rst_partial", oPartial, 0);
        check("rst_ovf", oOverflow, 0);
        iRst = 1'b1;
        tick();

        // Basic byte 1,0,1,1,0,0,1,0 -> 8'h4D
        iByteReady = 1'b1;
        rx_q.delete();
        iRX_EN = 1'b1;
        send_bits(8'h4D, 8);
        check("t1_valid", oByteValid, 1);
        check("t1_byte", oByte, 8'h4D);
        frame_end("t1");
        check("t1_cnt", oByteCnt, 1);
        check("t1_partial", oPartial, 0);
        check("t1_ovf", oOverflow, 0);
        tick();
        check("t1_done_clr", oFrameDone, 0);
        check("t1_nrx", rx_q.size(), 1);
        check_queue("t1_rx0", 0, 8'h4D);

        // Partial byte: 11 ones -> FF, 07
        rx_q.delete();
        iRX_EN = 1'b1;
        send_bits(8'hFF, 8);
        send_bits(8'h07, 3);
        frame_end("t2");
        check("t2_cnt", oByteCnt, 2);
        check("t2_partial", oPartial, 1);
        tick();
        check("t2_nrx", rx_q.size(), 2);
        check_queue("t2_rx0", 0, 8'hFF);
        check_queue("t2_rx1", 1, 8'h07);

        // Backpressure: 10 bytes into 8-deep FIFO
        iByteReady = 1'b0;
        rx_q.delete();
        iRX_EN = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            send_bits(k[7:0], 8);
        end
        frame_end("t3");
        check("t3_cnt", oByteCnt, 8);
        check("t3_ovf", oOverflow, 1);
        check("t3_partial", oPartial, 0);
        tick();
        iByteReady = 1'b1;
        repeat (12) tick();
        check("t3_nrx", rx_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check_queue("t3_rx", k, 8'(k + 1));
        end
        check("t3_empty", oByteValid, 0);
        check("t3_ovf_hold", oOverflow, 1);

        // Full FIFO with push and pop on the same edge
        iByteReady = 1'b0;
        rx_q.delete();
        iRX_EN = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send_bits(8'hA0 + 8'(k), 8);
        end
        send_bits(8'hA8, 7);
        iByteReady = 1'b1;
        send_bit(1'b1);
        frame_end("t4");
        check("t4_ovf", oOverflow, 0);
        check("t4_cnt", oByteCnt, 9);
        repeat (12) tick();
        check("t4_nrx", rx_q.size(), 9);
        for (int k = 0; k < 9; k++) begin
            check_queue("t4_rx", k, 8'hA0 + 8'(k));
        end

        // Reset mid-frame with a byte still buffered
        iByteReady = 1'b0;
        rx_q.delete();
        iRX_EN = 1'b1;
        send_bits(8'h3C, 8);
        send_bits(8'hFF, 5);
        check("t5_pre_valid", oByteValid, 1);
        check("t5_pre_cnt", oByteCnt, 1);
        #3;
        iRst = 1'b0;
        #1;
        check("t5_rst_valid", oByteValid, 0);
        check("t5_rst_byte", oByte, 0);
        check("t5_rst_cnt", oByteCnt, 0);
        iRX_EN = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            repeat (3) begin
                tick();
                seen = seen | oFrameDone;
            end
            check("t5_no_done", seen, 0);
        end
        #2;
        iRst = 1'b1;
        tick();
        iByteReady = 1'b1;
        iRX_EN = 1'b1;
        send_bits(8'h5A, 8);
        frame_end("t5");
        check("t5_cnt", oByteCnt, 1);
        check("t5_partial", oPartial, 0);
        check("t5_ovf", oOverflow, 0);
        repeat (3) tick();
        check("t5_nrx", rx_q.size(), 1);
        check_queue("t5_rx0", 0, 8'h5A);

`ifdef RX_PACK_CHKSUM_EN
        // Checksum: trailing XOR byte cancels to zero
        iRX_EN = 1'b1;
        send_bits(8'h12, 8);
        send_bits(8'h34, 8);
        send_bits(8'h26, 8);
        frame_end("t6");
        check("t6_chk", oChksum, 8'h00);
        check("t6_ok", oChksumOK, 1);
        tick();
        iRX_EN = 1'b1;
        send_bits(8'h12, 8);
        send_bits(8'h34, 8);
        frame_end("t7");
        check("t7_chk", oChksum, 8'h26);
        check("t7_ok", oChksumOK, 0);
        tick();
        check("t7_chk_hold", oChksum, 8'h26);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
